xgmii_tx_framer: RTL
====================

# xgmii_tx_framer

Transmit-side XGMII framer that converts a 64-bit byte stream (valid/ready/last/keep) into XGMII words (xgmii_txd/xgmii_txc) for the 10G PHY's XGMII transmit input. Inserts start/preamble/SFD, pads short frames, places the terminate character in the correct lane, enforces a minimum inter-frame gap, and signals underrun with an error word. FCS generation is out of scope; the upstream source supplies it.

## Interface
- DATA_WIDTH, 64, XGMII data width; only 64 supported.
- CTRL_WIDTH, 8, XGMII control width (DATA_WIDTH/8).
- MIN_FRAME_LEN, 60, minimum bytes after SFD; shorter frames are zero-padded.
- IFG_BYTES, 12, minimum idle bytes between terminate and next start.

- tx_clk  in  1  transmit clock; all logic on rising edge.
- tx_rst_n  in  1  synchronous, active-low reset.
- s_tdata  in  64  frame bytes; lane 0 = bits [7:0] = first byte.
- s_tkeep  in  8  byte enables; only meaningful with s_tlast.
- s_tvalid  in  1  beat valid.
- s_tlast  in  1  last beat of frame.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- xgmii_txd  out  64  XGMII data, registered.
- xgmii_txc  out  8  XGMII control, registered; bit i covers lane i.
- tx_start  out  1  one-cycle pulse when start word is driven.
- tx_underrun  out  1  one-cycle pulse when error word is driven.

## Operation
- Codes: idle 0x07, start 0xFB, terminate 0xFD, error 0xFE, preamble 0x55, SFD 0xD5.
- States: IDLE, DATA, PAD, TERM, DRAIN.
- IDLE: drive 0x0707070707070707/0xFF; s_tready=0. If s_tvalid and ifg_cnt >= IFG_BYTES: drive 0xD5555555555555FB/0x01, pulse tx_start, go DATA.
- DATA: s_tready=1. Accepted non-last beat: drive s_tdata/0x00, byte_cnt += 8 (s_tkeep ignored, treated 0xFF).
- Last beat: n = count of contiguous ones from bit 0 of s_tkeep; n=0 treated as 1. total = byte_cnt + n.
  - total < MIN_FRAME_LEN: lanes >= n zero-filled, txc=0x00, go PAD.
  - else n<8: lane n = 0xFD, lanes > n = 0x07, txc bits [7:n] set; ifg_cnt = 7-n; go IDLE.
  - else n=8: go TERM.
- PAD: s_tready=0; drive 0x00 bytes, txc=0x00, until MIN_FRAME_LEN reached; final pad word carries terminate at lane MIN_FRAME_LEN%8 per the rule above, or go TERM if remainder is 0.
- TERM: drive 0x07070707070707FD/0xFF, ifg_cnt = 7, go IDLE.
- DATA with s_tvalid=0 (underrun): drive 0xFEFEFEFEFEFEFEFE/0xFF, pulse tx_underrun, ifg_cnt = 0; go DRAIN (or IDLE if the frame's tlast was already accepted).
- DRAIN: s_tready=1, drive idle, discard beats until s_tlast accepted, then IDLE. Idle words in DRAIN count toward ifg_cnt.
- Every idle word driven in IDLE/DRAIN adds 8 to ifg_cnt; saturates at IFG_BYTES.
- byte_cnt: 16 bits, saturating at 0xFFFF, cleared on start word.

## Timing
- Reset (tx_rst_n low at edge): xgmii_txd=0x0707070707070707, xgmii_txc=0xFF, s_tready=0, tx_start=0, tx_underrun=0, state IDLE, byte_cnt=0, ifg_cnt=IFG_BYTES (immediate start allowed). Reset mid-frame abandons it with no terminate or error word.
- s_tready is combinational from state only (=1 in DATA/DRAIN); no combinational path from s_tvalid.
- Latency: start word at edge k+1 after s_tvalid seen at edge k; first beat accepted at edge k+2 and driven in that edge's output register; one cycle per beat.
- Start only in lane 0; frame-to-frame gap always whole idle words plus terminate-word idle lanes.

## Structure
- Package eth_xgmii_pkg: XGMII code constants, idle/preamble/error word constants, state enum.
- Sub-module xgmii_term_merge: combinational; given data word, lane n, and pad flag, produces merged txd/txc with terminate and idle fill.

## Test plan
- Reset: hold tx_rst_n low 3 cycles, release -> txd=0x0707070707070707, txc=0xFF, s_tready=0.
- 64-byte frame (8 beats, last tkeep 0xFF) -> 0xD5555555555555FB/0x01, 8 data words txc=0x00, then 0x07070707070707FD/0xFF.
- 61-byte frame (last tkeep 0x1F) -> final word lanes 0-4 data, lane 5 0xFD, lanes 6-7 0x07, txc=0xE0.
- 10-byte frame (tkeep 0x03) -> 7 words txc=0x00 (bytes 10-55 zero), 8th word lanes 0-3 zero, lane 4 0xFD, txc=0xF0; s_tready=0 during PAD.
- Back-to-back, first frame terminating in lane 5 (ifg 2) -> exactly two idle words (2+8+8=18 ≥ 12 after second) before next start.
- Underrun: drop s_tvalid on beat 3 -> 0xFEFEFEFEFEFEFEFE/0xFF, tx_underrun pulse, remaining beats drained with s_tready=1, idles out, next frame starts normally.

Source files
------------

// File: rtl/eth_xgmii_pkg.sv
`default_nettype none
// ============================================================
// eth_xgmii_pkg : XGMII codes, fixed words, framer state enum
// Rev 1.0
// ============================================================
package eth_xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_ERROR    = 8'hFE;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
  localparam logic [63:0] START_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
  localparam logic [63:0] ERROR_WORD = {8{XGMII_ERROR}};
  localparam logic [63:0] TERM_WORD  = {{7{XGMII_IDLE}}, XGMII_TERM};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAD   = 3'd2,
    ST_TERM  = 3'd3,
    ST_DRAIN = 3'd4
  } tx_state_e;

  // Contiguous run of ones from lane 0; an empty keep still carries one byte.
  function automatic logic [3:0] keep_to_lanes(input logic [7:0] keep);
    logic [3:0] n;
    logic       run;
    n   = 4'd0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run = run & keep[i];
      n   = n + {3'd0, run};
    end
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = (4'(i) < n) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [15:0] sat16(input logic [16:0] x);
    return x[16] ? 16'hFFFF : x[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/xgmii_term_merge.sv
`default_nettype none
// ============================================================
// xgmii_term_merge : places terminate at a lane, idle-fills above
// Rev 1.0
// ============================================================
module xgmii_term_merge
  import eth_xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  lane,
  input  logic        pad,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  // Lanes below the terminate carry data, or zeros when padding.
  always_comb begin
    txd = '0;
    txc = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < lane) begin
        txd[i*8 +: 8] = pad ? 8'h00 : data[i*8 +: 8];
        txc[i]        = 1'b0;
      end else if (3'(i) == lane) begin
        txd[i*8 +: 8] = XGMII_TERM;
        txc[i]        = 1'b1;
      end else begin
        txd[i*8 +: 8] = XGMII_IDLE;
        txc[i]        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xgmii_tx_framer.sv
`default_nettype none
// ============================================================
// xgmii_tx_framer : 64-bit byte stream to XGMII transmit words
// Rev 1.0
// ============================================================
module xgmii_tx_framer
  import eth_xgmii_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_BYTES     = 12
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [CTRL_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic                  tx_start,
  output logic                  tx_underrun
);

  localparam logic [16:0] MIN_LEN       = 17'(MIN_FRAME_LEN);
  localparam logic [2:0]  MIN_TERM_LANE = 3'(MIN_FRAME_LEN % 8);
  localparam logic [7:0]  IFG_MAX       = 8'(IFG_BYTES);
  localparam logic [7:0]  IFG_AFTER_MIN = 8'(7 - (MIN_FRAME_LEN % 8));

  tx_state_e   state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        start_q, start_d;
  logic        underrun_q, underrun_d;

  logic [3:0]  last_lanes;
  logic [16:0] total;
  logic [16:0] word_end;
  logic        short_frame;
  logic        start_ok;
  logic [7:0]  ifg_plus8;
  logic [63:0] merge_data, merge_txd;
  logic [7:0]  merge_txc;
  logic [2:0]  merge_lane;
  logic        merge_pad;

  assign last_lanes  = keep_to_lanes(s_tkeep);
  assign total       = {1'b0, byte_cnt_q} + {13'd0, last_lanes};
  assign word_end    = {1'b0, byte_cnt_q} + 17'd8;
  assign short_frame = (total < MIN_LEN);
  assign start_ok    = s_tvalid && (ifg_cnt_q >= IFG_MAX);
  assign ifg_plus8   = (({1'b0, ifg_cnt_q} + 9'd8) >= {1'b0, IFG_MAX}) ? IFG_MAX : (ifg_cnt_q + 8'd8);

  // A short last beat whose word already reaches the minimum gets its terminate
  // in the same word, with the gap between data and terminate zero-filled.
  assign merge_pad  = (state_q == ST_PAD);
  assign merge_lane = (merge_pad || short_frame) ? MIN_TERM_LANE : last_lanes[2:0];
  assign merge_data = s_tdata & lane_mask(last_lanes);

  xgmii_term_merge u_term_merge (
    .data (merge_data),
    .lane (merge_lane),
    .pad  (merge_pad),
    .txd  (merge_txd),
    .txc  (merge_txc)
  );

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      ifg_cnt_q  <= IFG_MAX;
      txd_q      <= IDLE_WORD;
      txc_q      <= 8'hFF;
      start_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      start_q    <= start_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_DATA;
          byte_cnt_d = '0;
        end else begin
          ifg_cnt_d = ifg_plus8;
        end
      end
      ST_DATA: begin
        if (!s_tvalid) begin
          state_d   = ST_DRAIN;
          ifg_cnt_d = '0;
        end else if (!s_tlast) begin
          byte_cnt_d = sat16(word_end);
        end else if (short_frame) begin
          byte_cnt_d = sat16(word_end);
          if (word_end > MIN_LEN) begin
            state_d   = ST_IDLE;
            ifg_cnt_d = IFG_AFTER_MIN;
          end else if (word_end == MIN_LEN) begin
            state_d = ST_TERM;
          end else begin
            state_d = ST_PAD;
          end
        end else if (last_lanes != 4'd8) begin
          state_d    = ST_IDLE;
          byte_cnt_d = sat16(total);
          ifg_cnt_d  = 8'd7 - {4'd0, last_lanes};
        end else begin
          state_d    = ST_TERM;
          byte_cnt_d = sat16(total);
        end
      end
      ST_PAD: begin
        byte_cnt_d = sat16(word_end);
        if (word_end == MIN_LEN) begin
          state_d = ST_TERM;
        end else if (word_end > MIN_LEN) begin
          state_d   = ST_IDLE;
          ifg_cnt_d = IFG_AFTER_MIN;
        end
      end
      ST_TERM: begin
        state_d   = ST_IDLE;
        ifg_cnt_d = 8'd7;
      end
      ST_DRAIN: begin
        ifg_cnt_d = ifg_plus8;
        if (s_tvalid && s_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_d      = IDLE_WORD;
    txc_d      = 8'hFF;
    start_d    = 1'b0;
    underrun_d = 1'b0;
    s_tready   = (state_q == ST_DATA) || (state_q == ST_DRAIN);
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          txd_d   = START_WORD;
          txc_d   = 8'h01;
          start_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (!s_tvalid) begin
          txd_d      = ERROR_WORD;
          underrun_d = 1'b1;
        end else if (!s_tlast) begin
          txd_d = s_tdata;
          txc_d = 8'h00;
        end else if ((short_frame && (word_end <= MIN_LEN)) || (last_lanes == 4'd8)) begin
          txd_d = merge_data;
          txc_d = 8'h00;
        end else begin
          txd_d = merge_txd;
          txc_d = merge_txc;
        end
      end
      ST_PAD: begin
        if (word_end <= MIN_LEN) begin
          txd_d = '0;
          txc_d = 8'h00;
        end else begin
          txd_d = merge_txd;
          txc_d = merge_txc;
        end
      end
      ST_TERM: begin
        txd_d = TERM_WORD;
        txc_d = 8'hFF;
      end
      ST_DRAIN: ;
      default: ;
    endcase
  end

  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign tx_start    = start_q;
  assign tx_underrun = underrun_q;

endmodule
`default_nettype wire
